// File: rtl/gf14_1rf_lg6_w32_byte.sv
// ----------------------------------------------------------------------------
// gf14_1rf_lg6_w32_byte
//
// Behavioural / synthesizable model of the GF14 single-port register-file
// macro: DEPTH words x DATA_W bits with one shared read/write port. Controls
// are active-low. Write enables are per bit. Read data is registered.
//
// Ports
//   CLK    in   1       clock, all accesses sample on the rising edge
//   RST    in   1       asynchronous reset, active-high (clears Q only)
//   CEN    in   1       chip enable, active-low
//   GWEN   in   1       global write enable, active-low (0 = write, 1 = read)
//   WEN    in   DATA_W  per-bit write enable, active-low
//   A      in   ADDR_W  word address
//   D      in   DATA_W  write data
//   Q      out  DATA_W  registered read data (1-cycle latency, holds otherwise)
//   EMA    in   3       extra margin adjust, timing only, ignored here
//   EMAW   in   2       write margin adjust, timing only, ignored here
//   RET1N  in   1       retention, active-low; blocks all accesses
// ----------------------------------------------------------------------------
module gf14_1rf_lg6_w32_byte #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CEN,
    input  logic              GWEN,
    input  logic [DATA_W-1:0] WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    input  logic [2:0]        EMA,
    input  logic [1:0]        EMAW,
    input  logic              RET1N
);

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    // Array is deliberately not reset: contents must survive RST.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] q_r;
    logic              access;
    logic              in_range;
    logic              do_write;
    logic              do_read;

    // Margin-adjust pins only tune timing on silicon.
    logic unused_margin;
    assign unused_margin = ^{EMA, EMAW};

    // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, A} < DEPTH_LIM);
    assign access   = !CEN && RET1N;
    assign do_write = access && !GWEN;
    assign do_read  = access && GWEN;

    // No write while RST is high: reset suspends all accesses, not just Q.
    always_ff @(posedge CLK) begin
        if (!RST && do_write && in_range) begin
            mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_r <= '0;
        end else if (do_read) begin
            q_r <= in_range ? mem[A] : '0;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_gf14_1rf_lg6_w32_byte.sv
// ----------------------------------------------------------------------------
// tb_gf14_1rf_lg6_w32_byte
//
// Directed self-checking bench for the 64x32 single-port register file.
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_gf14_1rf_lg6_w32_byte;

    logic        CLK;
    logic        RST;
    logic        CEN;
    logic        GWEN;
    logic [31:0] WEN;
    logic [5:0]  A;
    logic [31:0] D;
    logic [31:0] Q;
    logic [2:0]  EMA;
    logic [1:0]  EMAW;
    logic        RET1N;

    int vectors;
    int miscompares;

    gf14_1rf_lg6_w32_byte dut (
        .CLK   (CLK),
        .RST   (RST),
        .CEN   (CEN),
        .GWEN  (GWEN),
        .WEN   (WEN),
        .A     (A),
        .D     (D),
        .Q     (Q),
        .EMA   (EMA),
        .EMAW  (EMAW),
        .RET1N (RET1N)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [31:0] wen);
        CEN  = 1'b0;
        GWEN = 1'b0;
        A    = addr;
        D    = data;
        WEN  = wen;
        tick();
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
    endtask

    task automatic do_read(input logic [5:0] addr);
        CEN  = 1'b0;
        GWEN = 1'b1;
        A    = addr;
        tick();
        CEN  = 1'b1;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [31:0] held;

        vectors     = 0;
        miscompares = 0;
        RST   = 1'b1;
        CEN   = 1'b1;
        GWEN  = 1'b1;
        WEN   = '1;
        A     = '0;
        D     = '0;
        EMA   = 3'd3;
        EMAW  = 2'd1;
        RET1N = 1'b1;

        #3;
        check("reset_q", Q, 32'h0);
        tick();
        RST = 1'b0;

        // Write then read back; Q must not change during the write cycle.
        do_write(6'd5, 32'hDEADBEEF, 32'h0);
        check("write_no_q_change", Q, 32'h0);
        do_read(6'd5);
        check("read_a5", Q, 32'hDEADBEEF);

        // Async reset with Q nonzero, no clock edge involved.
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_q", Q, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        tick();
        tick();
        check("idle_after_rst", Q, 32'h0);

        // Byte-masked write.
        do_write(6'd9, 32'h11223344, 32'h0);
        do_write(6'd9, 32'hAABBCCDD, 32'h00FFFF00);
        do_read(6'd9);
        check("byte_mask", Q, 32'hAA2233DD);

        // GWEN=0 with all WEN high: nothing written, Q holds.
        do_write(6'd9, 32'h55555555, 32'hFFFFFFFF);
        check("wen_all_ones_q_hold", Q, 32'hAA2233DD);
        do_read(6'd9);
        check("wen_all_ones_mem", Q, 32'hAA2233DD);

        // Back-to-back write then read of the same address.
        CEN = 1'b0; GWEN = 1'b0; A = 6'd20; D = 32'hCAFEF00D; WEN = '0;
        tick();
        GWEN = 1'b1; WEN = '1;
        tick();
        CEN = 1'b1;
        check("back_to_back", Q, 32'hCAFEF00D);

        // Fill every address, read back in reverse order.
        for (int a = 0; a < 64; a++) begin
            pat = {a[5:0], 2'b01};
            do_write(a[5:0], {4{pat}}, 32'h0);
        end
        for (int a = 63; a >= 0; a--) begin
            pat = {a[5:0], 2'b01};
            do_read(a[5:0]);
            check($sformatf("fill_rd_%0d", a), Q, {4{pat}});
            if (a == 63) check("addr63", Q, 32'hFDFDFDFD);
            if (a == 0)  check("addr0", Q, 32'h01010101);
        end

        // Idle cycles with moving inputs must not disturb Q or the array.
        do_read(6'd3);
        check("read_a3", Q, 32'h0D0D0D0D);
        CEN = 1'b1; GWEN = 1'b0; WEN = '0;
        A = 6'd3; D = 32'h12345678; tick();
        check("idle1_q", Q, 32'h0D0D0D0D);
        A = 6'd4; D = 32'h87654321; GWEN = 1'b1; tick();
        check("idle2_q", Q, 32'h0D0D0D0D);
        A = 6'd3; D = 32'hFFFFFFFF; GWEN = 1'b0; tick();
        check("idle3_q", Q, 32'h0D0D0D0D);
        GWEN = 1'b1; WEN = '1;
        do_read(6'd4);
        check("idle_mem_a4", Q, 32'h11111111);
        do_read(6'd3);
        check("idle_mem_a3", Q, 32'h0D0D0D0D);

        // Retention: write and read both ignored.
        RET1N = 1'b0;
        do_write(6'd3, 32'hFFFFFFFF, 32'h0);
        check("ret_write_q_hold", Q, 32'h0D0D0D0D);
        do_read(6'd10);
        check("ret_read_q_hold", Q, 32'h0D0D0D0D);
        RET1N = 1'b1;
        do_read(6'd3);
        check("ret_mem_a3", Q, 32'h0D0D0D0D);

        // Reset mid-sequence: array survives, and no access happens while held.
        do_write(6'd7, 32'h0F0F0F0F, 32'h0);
        do_read(6'd9);
        held = 32'h25252525;
        check("pre_rst_q", Q, held);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_q", Q, 32'h0);
        CEN = 1'b0; GWEN = 1'b0; A = 6'd7; D = 32'h0; WEN = '0;
        tick();
        check("rst_held_q", Q, 32'h0);
        CEN = 1'b1; GWEN = 1'b1; WEN = '1;
        RST = 1'b0;
        tick();
        do_read(6'd7);
        check("mem_survives_rst", Q, 32'h0F0F0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
